// File: rtl/const_table_rf.sv
// Operand-pointer decoder with a writable constant table that self-loads the ISA
// default constants after reset or reload; NUM_RD independent registered read ports.
module const_table_rf #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4,
    parameter int NUM_RD = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        reload,
    output logic                        busy,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_err,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*(IDX_W+1)-1:0] rd_ptr,
    output logic [NUM_RD*DATA_W-1:0]    rd_val,
    output logic [NUM_RD-1:0]           rd_flag,
    output logic [NUM_RD-1:0]           rd_valid
);

    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0]          table_q [DEPTH];
    logic [DATA_W-1:0]          table_d [DEPTH];
    logic                       wr_err_q, wr_err_d;
    logic [NUM_RD*DATA_W-1:0]   rd_val_q, rd_val_d;
    logic [NUM_RD-1:0]          rd_flag_q, rd_flag_d;
    logic [NUM_RD-1:0]          rd_valid_q, rd_valid_d;
    logic                       wr_fire;
    logic [IDX_W:0]             ptr;
    logic [IDX_W-1:0]           idx;

    // ISA default constants; entries beyond 15 are zero, values resized to DATA_W.
    function automatic logic [DATA_W-1:0] default_const(input logic [IDX_W-1:0] i);
        logic [7:0] v;
        case (int'(i))
            0:       v = 8'd127;
            1:       v = 8'd1;
            2:       v = 8'd2;
            3:       v = 8'd128;
            4:       v = 8'd8;
            5:       v = 8'd3;
            6:       v = 8'd4;
            7:       v = 8'd5;
            8:       v = 8'd32;
            9:       v = 8'd6;
            10:      v = 8'd15;
            11:      v = 8'd64;
            12:      v = 8'd7;
            13:      v = 8'd255;
            14:      v = 8'd19;
            15:      v = 8'd20;
            default: v = 8'd0;
        endcase
        return DATA_W'(v);
    endfunction

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        table_d    = table_q;
        wr_err_d   = 1'b0;
        wr_fire    = 1'b0;
        rd_val_d   = rd_val_q;
        rd_flag_d  = rd_flag_q;
        rd_valid_d = '0;
        ptr        = '0;
        idx        = '0;
        busy       = (state_q == ST_INIT);

        case (state_q)
            ST_INIT: begin
                table_d[init_cnt_q] = default_const(init_cnt_q);
                init_cnt_d          = init_cnt_q + IDX_W'(1);
                if (&init_cnt_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (wr_en && !reload) begin
                    wr_fire         = 1'b1;
                    table_d[wr_idx] = wr_data;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // A write colliding with busy or with a reload request is dropped and flagged.
        if (wr_en && (busy || reload)) begin
            wr_err_d = 1'b1;
        end
        if (reload) begin
            state_d    = ST_INIT;
            init_cnt_d = '0;
        end

        for (int i = 0; i < NUM_RD; i++) begin
            ptr = rd_ptr[i*(IDX_W+1) +: (IDX_W+1)];
            idx = ptr[IDX_W-1:0];
            if (!busy && rd_en[i]) begin
                rd_valid_d[i] = 1'b1;
                rd_flag_d[i]  = ptr[IDX_W];
                if (!ptr[IDX_W]) begin
                    rd_val_d[i*DATA_W +: DATA_W] = DATA_W'(idx);
                end else if (wr_fire && (wr_idx == idx)) begin
                    rd_val_d[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_val_d[i*DATA_W +: DATA_W] = table_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wr_err_q   <= 1'b0;
            rd_val_q   <= '0;
            rd_flag_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_err_q   <= wr_err_d;
            rd_val_q   <= rd_val_d;
            rd_flag_q  <= rd_flag_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Table storage is deliberately unreset: INIT rewrites every entry.
    always_ff @(posedge clk) begin
        table_q <= table_d;
    end

    assign wr_err   = wr_err_q;
    assign rd_val   = rd_val_q;
    assign rd_flag  = rd_flag_q;
    assign rd_valid = rd_valid_q;

endmodule
